// File: rtl/dkongjr_pkg.sv
// Shared definitions for the Donkey Kong Jr. VRAM CPU interface.
//   vram_state_e : access sequencer states
//   StrobeCycMax : largest legal VRAM strobe length in CLK_12M cycles
//   StrobeCntW   : width of the strobe-length counter
//   cpu_req()    : decode of a live CPU request into the VRAM window
package dkongjr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitBusy,
    StAccess,
    StDone
  } vram_state_e;

  localparam int unsigned StrobeCycMax = 7;
  localparam int unsigned StrobeCntW   = $clog2(StrobeCycMax + 1);
  localparam int unsigned VramAbW      = 10;
  localparam int unsigned VramDbW      = 8;

  function automatic logic cpu_req(input logic sel, input logic rdn, input logic wrn);
    return sel & (~rdn | ~wrn);
  endfunction

endpackage

// File: rtl/dkongjr_vram_wbuf.sv
// One-entry posted-write buffer for the VRAM CPU interface.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (drops any buffered write)
//   push_i        : capture ab_i/db_i and mark the entry valid
//   pop_i         : release the entry once its VRAM write has finished
//   valid_o       : entry holds a write not yet retired
//   ab_o, db_o    : buffered address and data
module dkongjr_vram_wbuf
  import dkongjr_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [VramAbW-1:0] ab_i,
  input  logic [VramDbW-1:0] db_i,
  output logic               valid_o,
  output logic [VramAbW-1:0] ab_o,
  output logic [VramDbW-1:0] db_o
);

  logic               valid_q, valid_d;
  logic [VramAbW-1:0] ab_q, ab_d;
  logic [VramDbW-1:0] db_q, db_d;

  always_comb begin
    valid_d = valid_q;
    ab_d    = ab_q;
    db_d    = db_q;
    if (push_i) begin
      valid_d = 1'b1;
      ab_d    = ab_i;
      db_d    = db_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ab_q    <= '0;
      db_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ab_q    <= ab_d;
      db_q    <= db_d;
    end
  end

  assign valid_o = valid_q;
  assign ab_o    = ab_q;
  assign db_o    = db_q;

endmodule

// File: rtl/dkongjr_vram_cpu_if.sv
// CPU-side VRAM access sequencer for Donkey Kong Jr.
// Arbitrates one CPU read/write per CPU bus cycle against video ownership of VRAM
// (I_VRAMBUSYn), drives the VRAM strobes and stalls the CPU through O_WAITn.
// Ports:
//   CLK_12M, I_RSTn            : clock, asynchronous active-low reset
//   I_SEL, I_RDn, I_WRn        : CPU window decode and strobes (read wins if both low)
//   I_AB, I_DB                 : CPU address / write data
//   O_DB                       : last read data, held until the next read completes
//   O_WAITn                    : CPU wait request, active low
//   O_VRAM_AB, O_VRAM_DB       : VRAM address / write data
//   O_VRAM_WRn, O_VRAM_RDn     : VRAM strobes, active low, STROBE_CYC cycles long
//   I_VRAM_DB, I_VRAMBUSYn     : VRAM read data, video-owns-VRAM flag (low = busy)
//   O_PEND                     : posted write buffered
// Build option: define DKONGJR_VRAM_WRITE_POST_EN to post writes into a one-entry
// buffer so the CPU is not stalled by them; otherwise O_PEND is tied 0.
module dkongjr_vram_cpu_if
  import dkongjr_pkg::*;
#(
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic        CLK_12M,
  input  logic        I_RSTn,
  input  logic        I_SEL,
  input  logic        I_RDn,
  input  logic        I_WRn,
  input  logic [9:0]  I_AB,
  input  logic [7:0]  I_DB,
  output logic [7:0]  O_DB,
  output logic        O_WAITn,
  output logic [9:0]  O_VRAM_AB,
  output logic [7:0]  O_VRAM_DB,
  output logic        O_VRAM_WRn,
  output logic        O_VRAM_RDn,
  input  logic [7:0]  I_VRAM_DB,
  input  logic        I_VRAMBUSYn,
  output logic        O_PEND
);

  // Counter value on the last ACCESS cycle; the first ACCESS cycle is address setup.
  localparam logic [StrobeCntW-1:0] StrobeLast = StrobeCntW'(STROBE_CYC);

  vram_state_e            state_q, state_d;
  logic                   busyn_q;
  logic [VramAbW-1:0]     ab_q, ab_d;
  logic [VramDbW-1:0]     db_q, db_d;
  logic [VramDbW-1:0]     rd_q, rd_d;
  logic                   is_rd_q, is_rd_d;
  logic [StrobeCntW-1:0]  cnt_q, cnt_d;
  logic                   wrn_q, wrn_d;
  logic                   rdn_q, rdn_d;
  // served: the current CPU cycle has been accepted; posted: it was accepted as a
  // posted write; cur_posted: the access in flight is a buffer drain.
  logic                   served_q, served_d;
  logic                   posted_q, posted_d;
  logic                   cur_posted_q, cur_posted_d;

  logic                   req;
  logic                   post_ok;
  logic                   wb_valid;
  logic [VramAbW-1:0]     wb_ab;
  logic [VramDbW-1:0]     wb_db;

  assign req = cpu_req(I_SEL, I_RDn, I_WRn);

`ifdef DKONGJR_VRAM_WRITE_POST_EN
  logic wb_push, wb_pop;

  // A fresh write with the buffer empty is taken without stalling the CPU.
  assign post_ok = (state_q == StIdle) & ~served_q & req & I_RDn & ~wb_valid;
  assign wb_push = post_ok;
  assign wb_pop  = (state_q == StDone) & cur_posted_q;

  dkongjr_vram_wbuf u_wbuf (
    .clk_i   (CLK_12M),
    .rst_ni  (I_RSTn),
    .push_i  (wb_push),
    .pop_i   (wb_pop),
    .ab_i    (I_AB),
    .db_i    (I_DB),
    .valid_o (wb_valid),
    .ab_o    (wb_ab),
    .db_o    (wb_db)
  );
`else
  assign post_ok  = 1'b0;
  assign wb_valid = 1'b0;
  assign wb_ab    = '0;
  assign wb_db    = '0;
`endif

  always_comb begin
    state_d      = state_q;
    ab_d         = ab_q;
    db_d         = db_q;
    rd_d         = rd_q;
    is_rd_d      = is_rd_q;
    cnt_d        = cnt_q;
    wrn_d        = 1'b1;
    rdn_d        = 1'b1;
    served_d     = served_q;
    posted_d     = posted_q;
    cur_posted_d = cur_posted_q;

    if (!req) begin
      served_d = 1'b0;
      posted_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (wb_valid) begin
          // Drain the buffered write ahead of any new CPU request.
          ab_d         = wb_ab;
          db_d         = wb_db;
          is_rd_d      = 1'b0;
          cur_posted_d = 1'b1;
          cnt_d        = '0;
          state_d      = busyn_q ? StAccess : StWaitBusy;
        end else if (req && !served_q) begin
          served_d = 1'b1;
          if (post_ok) begin
            posted_d = 1'b1;
          end else begin
            ab_d         = I_AB;
            db_d         = I_DB;
            is_rd_d      = ~I_RDn;
            cur_posted_d = 1'b0;
            cnt_d        = '0;
            state_d      = busyn_q ? StAccess : StWaitBusy;
          end
        end
      end
      StWaitBusy: begin
        if (busyn_q) state_d = StAccess;
      end
      StAccess: begin
        // Busy is deliberately ignored here: an access, once started, runs to length.
        if (cnt_q != StrobeLast) begin
          rdn_d = ~is_rd_q;
          wrn_d = is_rd_q;
          cnt_d = cnt_q + StrobeCntW'(1);
        end else begin
          state_d = StDone;
          if (is_rd_q) rd_d = I_VRAM_DB;
        end
      end
      StDone: begin
        if (cur_posted_q || !req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_12M or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q      <= StIdle;
      busyn_q      <= 1'b0;
      ab_q         <= '0;
      db_q         <= '0;
      rd_q         <= '0;
      is_rd_q      <= 1'b0;
      cnt_q        <= '0;
      wrn_q        <= 1'b1;
      rdn_q        <= 1'b1;
      served_q     <= 1'b0;
      posted_q     <= 1'b0;
      cur_posted_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busyn_q      <= I_VRAMBUSYn;
      ab_q         <= ab_d;
      db_q         <= db_d;
      rd_q         <= rd_d;
      is_rd_q      <= is_rd_d;
      cnt_q        <= cnt_d;
      wrn_q        <= wrn_d;
      rdn_q        <= rdn_d;
      served_q     <= served_d;
      posted_q     <= posted_d;
      cur_posted_q <= cur_posted_d;
    end
  end

  // Stall any live CPU cycle that is neither posted nor finished. DONE of a drain
  // does not release a CPU cycle that arrived behind the posted write.
  assign O_WAITn = ~I_RSTn |
                   ~(req & ~post_ok & ~(served_q & posted_q) &
                     ~((state_q == StDone) & ~cur_posted_q));

  assign O_DB       = rd_q;
  assign O_VRAM_AB  = ab_q;
  assign O_VRAM_DB  = db_q;
  assign O_VRAM_WRn = wrn_q;
  assign O_VRAM_RDn = rdn_q;
  assign O_PEND     = wb_valid;

endmodule

// File: tb/tb_dkongjr_vram_cpu_if.sv
// Scoreboard bench for dkongjr_vram_cpu_if: stimulus queues expected VRAM accesses
// and read data, a negedge monitor pops and compares as the DUT produces them.
module tb_dkongjr_vram_cpu_if;
  import dkongjr_pkg::*;

  localparam int unsigned StrobeCyc = 2;

  logic       CLK_12M;
  logic       I_RSTn;
  logic       I_SEL, I_RDn, I_WRn;
  logic [9:0] I_AB;
  logic [7:0] I_DB;
  logic [7:0] O_DB;
  logic       O_WAITn;
  logic [9:0] O_VRAM_AB;
  logic [7:0] O_VRAM_DB;
  logic       O_VRAM_WRn, O_VRAM_RDn;
  logic [7:0] I_VRAM_DB;
  logic       I_VRAMBUSYn;
  logic       O_PEND;

  dkongjr_vram_cpu_if #(.STROBE_CYC(StrobeCyc)) dut (
    .CLK_12M     (CLK_12M),
    .I_RSTn      (I_RSTn),
    .I_SEL       (I_SEL),
    .I_RDn       (I_RDn),
    .I_WRn       (I_WRn),
    .I_AB        (I_AB),
    .I_DB        (I_DB),
    .O_DB        (O_DB),
    .O_WAITn     (O_WAITn),
    .O_VRAM_AB   (O_VRAM_AB),
    .O_VRAM_DB   (O_VRAM_DB),
    .O_VRAM_WRn  (O_VRAM_WRn),
    .O_VRAM_RDn  (O_VRAM_RDn),
    .I_VRAM_DB   (I_VRAM_DB),
    .I_VRAMBUSYn (I_VRAMBUSYn),
    .O_PEND      (O_PEND)
  );

  initial CLK_12M = 1'b0;
  always #5 CLK_12M = ~CLK_12M;

  typedef struct packed {
    logic       wr;
    logic [9:0] ab;
    logic [7:0] db;
  } acc_t;

  acc_t       exp_acc[$];
  logic [7:0] exp_rd[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_min(input string name, input int got, input int min);
    checks++;
    if (got < min) begin
      errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, got, min);
    end
  endtask

  // VRAM model: combinational read, write sampled while the write strobe is low.
  logic [7:0] vram [1024];
  logic       vram_init = 1'b0;
  assign I_VRAM_DB = vram[O_VRAM_AB];

  always @(negedge CLK_12M) begin
    if (!vram_init) begin
      for (int i = 0; i < 1024; i++) vram[i] = 8'h00;
      vram[10'h3A5] = 8'h5C;
      vram_init = 1'b1;
    end else if (!O_VRAM_WRn) begin
      vram[O_VRAM_AB] = O_VRAM_DB;
    end
  end

  // Monitor
  logic       in_pulse = 1'b0;
  int         low_cnt = 0;
  logic [9:0] pulse_ab = '0;
  logic       wait_prev = 1'b1;

  always @(negedge CLK_12M) begin
    acc_t e;
    if (!I_RSTn) begin
      in_pulse  = 1'b0;
      low_cnt   = 0;
      wait_prev = 1'b1;
    end else begin
      if (!O_VRAM_WRn || !O_VRAM_RDn) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          low_cnt  = 1;
          pulse_ab = O_VRAM_AB;
          if (exp_acc.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_access: got wr=%0b ab=0x%0h, none expected",
                     !O_VRAM_WRn, O_VRAM_AB);
          end else begin
            e = exp_acc.pop_front();
            check("acc_dir_wr", {31'd0, !O_VRAM_WRn}, {31'd0, e.wr});
            check("acc_dir_rd", {31'd0, !O_VRAM_RDn}, {31'd0, !e.wr});
            check("acc_ab", {22'd0, O_VRAM_AB}, {22'd0, e.ab});
            if (e.wr) check("acc_db", {24'd0, O_VRAM_DB}, {24'd0, e.db});
          end
        end else begin
          low_cnt++;
          check("ab_stable_in_pulse", {22'd0, O_VRAM_AB}, {22'd0, pulse_ab});
        end
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        check("strobe_width", low_cnt, StrobeCyc);
        check("ab_hold_after", {22'd0, O_VRAM_AB}, {22'd0, pulse_ab});
      end

      if (I_SEL && !I_RDn && !wait_prev && O_WAITn) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read_done: got O_DB=0x%0h, none expected", O_DB);
        end else begin
          check("rd_data", {24'd0, O_DB}, {24'd0, exp_rd.pop_front()});
        end
      end
      wait_prev = O_WAITn;
    end
  end

  // One CPU bus cycle; returns the number of sampled cycles O_WAITn was low.
  task automatic cpu_access(input logic rd, input logic [9:0] ab, input logic [7:0] db,
                            input int hold, output int wcnt);
    @(posedge CLK_12M);
    #1;
    I_SEL = 1'b1;
    I_AB  = ab;
    I_DB  = db;
    if (rd) I_RDn = 1'b0;
    else    I_WRn = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK_12M);
      if (O_WAITn) break;
      wcnt++;
    end
    if (!O_WAITn) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: got O_WAITn=0 after %0d cycles, required release", wcnt);
    end
    repeat (hold) @(posedge CLK_12M);
    @(posedge CLK_12M);
    #1;
    I_SEL = 1'b0;
    I_RDn = 1'b1;
    I_WRn = 1'b1;
    repeat (2) @(posedge CLK_12M);
  endtask

  task automatic do_read(input logic [9:0] ab, input logic [7:0] exp, output int wcnt);
    exp_acc.push_back('{wr: 1'b0, ab: ab, db: 8'h00});
    exp_rd.push_back(exp);
    cpu_access(1'b1, ab, 8'h00, 0, wcnt);
  endtask

  task automatic do_write(input logic [9:0] ab, input logic [7:0] db, input int hold,
                          output int wcnt);
    exp_acc.push_back('{wr: 1'b1, ab: ab, db: db});
    cpu_access(1'b0, ab, db, hold, wcnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wc, wc2;
    I_RSTn      = 1'b0;
    I_SEL       = 1'b0;
    I_RDn       = 1'b1;
    I_WRn       = 1'b1;
    I_AB        = '0;
    I_DB        = '0;
    I_VRAMBUSYn = 1'b1;

    // Reset values, with a live CPU read that must not pull wait low.
    repeat (2) @(posedge CLK_12M);
    #1;
    I_SEL = 1'b1;
    I_RDn = 1'b0;
    I_AB  = 10'h155;
    #1;
    check("rst_vram_wrn", {31'd0, O_VRAM_WRn}, 32'd1);
    check("rst_vram_rdn", {31'd0, O_VRAM_RDn}, 32'd1);
    check("rst_waitn", {31'd0, O_WAITn}, 32'd1);
    check("rst_o_db", {24'd0, O_DB}, 32'd0);
    check("rst_vram_ab", {22'd0, O_VRAM_AB}, 32'd0);
    check("rst_vram_db", {24'd0, O_VRAM_DB}, 32'd0);
    check("rst_pend", {31'd0, O_PEND}, 32'd0);
    check("rst_busyn_q", {31'd0, dut.busyn_q}, 32'd0);
    check("rst_state", {30'd0, dut.state_q}, {30'd0, StIdle});
    I_SEL = 1'b0;
    I_RDn = 1'b1;
    @(posedge CLK_12M);
    #1 I_RSTn = 1'b1;
    repeat (3) @(posedge CLK_12M);

    // Read with VRAM free: strobe setup cycle plus STROBE_CYC strobe cycles.
    do_read(10'h3A5, 8'h5C, wc);
    check("rd_wait_cycles", wc, StrobeCyc + 2);

`ifdef DKONGJR_VRAM_WRITE_POST_EN
    // Posted write while video owns VRAM, then a read that must wait for the drain.
    #1 I_VRAMBUSYn = 1'b0;
    do_write(10'h0AA, 8'h96, 0, wc);
    check("post_wr_wait", wc, 0);
    check("post_pend_set", {31'd0, O_PEND}, 32'd1);
    exp_acc.push_back('{wr: 1'b0, ab: 10'h0AA, db: 8'h00});
    exp_rd.push_back(8'h96);
    fork
      begin
        repeat (30) @(posedge CLK_12M);
        #1 I_VRAMBUSYn = 1'b1;
      end
      cpu_access(1'b1, 10'h0AA, 8'h00, 0, wc2);
    join
    check_min("post_rd_wait", wc2, 30);
    check("post_pend_clear", {31'd0, O_PEND}, 32'd0);
`else
    // Write while video owns VRAM for 40 cycles: CPU stalls the whole time.
    #1 I_VRAMBUSYn = 1'b0;
    exp_acc.push_back('{wr: 1'b1, ab: 10'h011, db: 8'h7E});
    fork
      begin
        repeat (20) @(posedge CLK_12M);
        #1 check("pend_tied0", {31'd0, O_PEND}, 32'd0);
        repeat (20) @(posedge CLK_12M);
        #1 I_VRAMBUSYn = 1'b1;
      end
      cpu_access(1'b0, 10'h011, 8'h7E, 0, wc);
    join
    check_min("busy_wr_wait", wc, 40);
    do_read(10'h011, 8'h7E, wc);
`endif

    // Busy falls in the middle of an access: no abort, no extension, no repeat.
    exp_acc.push_back('{wr: 1'b0, ab: 10'h3A5, db: 8'h00});
    exp_rd.push_back(8'h5C);
    fork
      begin
        repeat (3) @(posedge CLK_12M);
        #1 I_VRAMBUSYn = 1'b0;
        repeat (5) @(posedge CLK_12M);
        #1 I_VRAMBUSYn = 1'b1;
      end
      cpu_access(1'b1, 10'h3A5, 8'h00, 0, wc);
    join
    check("busy_drop_rd_wait", wc, StrobeCyc + 2);
    repeat (3) @(posedge CLK_12M);

    // CPU holds the write strobe for 20 extra cycles: still one VRAM write.
    do_write(10'h155, 8'h3C, 20, wc);
    do_read(10'h155, 8'h3C, wc);

    // Reset in the middle of a write strobe.
    exp_acc.push_back('{wr: 1'b1, ab: 10'h0F0, db: 8'h11});
    @(posedge CLK_12M);
    #1;
    I_SEL = 1'b1;
    I_AB  = 10'h0F0;
    I_DB  = 8'h11;
    I_WRn = 1'b0;
    wc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK_12M);
      if (!O_VRAM_WRn) break;
      wc++;
    end
    if (O_VRAM_WRn) begin
      checks++;
      errors++;
      $display("FAIL rst_mid_no_strobe: got no write strobe after %0d cycles", wc);
    end
    @(posedge CLK_12M);
    #2 I_RSTn = 1'b0;
    #1;
    check("rst_mid_wrn", {31'd0, O_VRAM_WRn}, 32'd1);
    check("rst_mid_rdn", {31'd0, O_VRAM_RDn}, 32'd1);
    check("rst_mid_pend", {31'd0, O_PEND}, 32'd0);
    check("rst_mid_state", {30'd0, dut.state_q}, {30'd0, StIdle});
    check("rst_mid_waitn", {31'd0, O_WAITn}, 32'd1);
    I_SEL = 1'b0;
    I_WRn = 1'b1;
    @(posedge CLK_12M);
    #1 I_RSTn = 1'b1;
    repeat (5) @(posedge CLK_12M);

    check("acc_queue_empty", exp_acc.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
